// File: rtl/tick_scheduler.sv
// tick_scheduler: three-channel clock divider with a start/stop sequencer.
//
// Each channel i produces a 50% duty square wave of period DIVi clk cycles on
// div_out_o[i] and a one-cycle tick_o[i] pulse in the first cycle the wave is
// high. A stop request lets every channel finish its current high half and
// park at the start of a low half before the block returns to idle, so no high
// pulse is ever cut short.
//
// Ports:
//   clk_i          clock, all state on the rising edge
//   rst_ni         asynchronous active-low reset
//   start_i        one-cycle request to begin generation
//   stop_i         one-cycle request to end generation cleanly
//   div_out_o[2:0] divided square waves
//   tick_o[2:0]    one-cycle pulse per rising edge of div_out_o[i]
//   busy_o         high whenever the sequencer is not idle
//   run_cycles_o   (only with TICK_SCHED_CNT_EN defined) saturating count of
//                  clk edges spent in the run state
//
// Configuration macro: TICK_SCHED_CNT_EN adds run_cycles_o and its counter.

module tick_scheduler #(
  parameter int unsigned DIV0  = 2,
  parameter int unsigned DIV1  = 4,
  parameter int unsigned DIV2  = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        stop_i,
  output logic [2:0]  div_out_o,
  output logic [2:0]  tick_o,
  output logic        busy_o
`ifdef TICK_SCHED_CNT_EN
  ,
  output logic [15:0] run_cycles_o
`endif
);

  typedef enum logic [1:0] {StIdle, StArm, StRun, StDrain} state_e;

  // Terminal count of each half-period counter.
  localparam int unsigned HalfM1 [3] = '{DIV0 / 2 - 1, DIV1 / 2 - 1, DIV2 / 2 - 1};

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q [3];
  logic [2:0]       div_q;
  logic [2:0]       tick_q;
  logic             busy_q;

  logic [2:0] wrap;    // counter at terminal count: wraps and toggles this edge
  logic [2:0] frozen;  // channel parked at the start of a low half
  logic [2:0] adv;     // channel advances on this edge

  always_comb begin
    wrap   = '0;
    frozen = '0;
    for (int i = 0; i < 3; i++) begin
      wrap[i]   = (cnt_q[i] == CNT_W'(HalfM1[i]));
      frozen[i] = ~div_q[i] && (cnt_q[i] == '0);
    end
  end

  always_comb begin
    adv = '0;
    if (state_q == StRun) begin
      adv = '1;
    end else if (state_q == StDrain) begin
      adv = ~frozen;
    end
  end

`ifdef TICK_SCHED_CNT_EN
  logic [15:0] run_cycles_q;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= '0;
      end
      div_q  <= '0;
      tick_q <= '0;
      busy_q <= 1'b0;
`ifdef TICK_SCHED_CNT_EN
      run_cycles_q <= '0;
`endif
    end else begin
      tick_q <= '0;

      for (int i = 0; i < 3; i++) begin
        if (adv[i]) begin
          cnt_q[i]  <= wrap[i] ? '0 : cnt_q[i] + CNT_W'(1);
          div_q[i]  <= div_q[i] ^ wrap[i];
          tick_q[i] <= wrap[i] & ~div_q[i];
        end
      end

      case (state_q)
        StIdle: begin
          // Stop wins over a simultaneous start.
          if (start_i && !stop_i) begin
            state_q <= StArm;
            busy_q  <= 1'b1;
          end
        end

        StArm: begin
          for (int i = 0; i < 3; i++) begin
            cnt_q[i] <= '0;
          end
          div_q <= '0;
`ifdef TICK_SCHED_CNT_EN
          run_cycles_q <= '0;
`endif
          if (stop_i) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else begin
            state_q <= StRun;
          end
        end

        StRun: begin
`ifdef TICK_SCHED_CNT_EN
          if (run_cycles_q != 16'hFFFF) begin
            run_cycles_q <= run_cycles_q + 16'd1;
          end
`endif
          // start is ignored here; only stop matters.
          if (stop_i) begin
            state_q <= StDrain;
          end
        end

        StDrain: begin
          if (&frozen) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end

        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign div_out_o = div_q;
  assign tick_o    = tick_q;
  assign busy_o    = busy_q;
`ifdef TICK_SCHED_CNT_EN
  assign run_cycles_o = run_cycles_q;
`endif

endmodule

// File: tb/tb_tick_scheduler.sv
// Self-checking bench for tick_scheduler with default parameters (2/4/8).
// Directed table, a few hand sequences and a randomized run compared against
// a phase-based reference model. Define TICK_SCHED_CNT_EN to also cover
// run_cycles.

module tb_tick_scheduler;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic [2:0] div_out;
  logic [2:0] tick;
  logic       busy;
`ifdef TICK_SCHED_CNT_EN
  logic [15:0] run_cycles;
`endif

  tick_scheduler dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .start_i   (start),
    .stop_i    (stop),
    .div_out_o (div_out),
    .tick_o    (tick),
    .busy_o    (busy)
`ifdef TICK_SCHED_CNT_EN
    ,
    .run_cycles_o (run_cycles)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  localparam int D [3] = '{2, 4, 8};

  // Reference model: each channel is a phase position p in [0, D) counted in
  // run edges; the wave is high for p >= D/2 and rises when p becomes D/2.
  int         m_state;  // 0 idle, 1 arm, 2 run, 3 drain
  int         m_p [3];
  logic [2:0] m_tick;
  int         m_rc;

  function automatic void model_reset();
    m_state = 0;
    for (int i = 0; i < 3; i++) m_p[i] = 0;
    m_tick = '0;
    m_rc   = 0;
  endfunction

  function automatic void model_step(input logic s, input logic t);
    bit all_low;
    all_low = 1'b1;
    for (int i = 0; i < 3; i++) if (m_p[i] != 0) all_low = 1'b0;
    m_tick = '0;
    case (m_state)
      0: if (s && !t) m_state = 1;
      1: begin
        for (int i = 0; i < 3; i++) m_p[i] = 0;
        m_rc    = 0;
        m_state = t ? 0 : 2;
      end
      2: begin
        for (int i = 0; i < 3; i++) begin
          m_p[i] = (m_p[i] + 1) % D[i];
          if (m_p[i] == D[i] / 2) m_tick[i] = 1'b1;
        end
        if (m_rc < 65535) m_rc++;
        if (t) m_state = 3;
      end
      3: begin
        for (int i = 0; i < 3; i++) begin
          if (m_p[i] != 0) begin
            m_p[i] = (m_p[i] + 1) % D[i];
            if (m_p[i] == D[i] / 2) m_tick[i] = 1'b1;
          end
        end
        if (all_low) m_state = 0;
      end
      default: ;
    endcase
  endfunction

  function automatic logic [6:0] model_out();
    logic [2:0] d;
    for (int i = 0; i < 3; i++) d[i] = (m_p[i] >= D[i] / 2);
    return {d, m_tick, (m_state != 0)};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string name);
    check(name, {9'd0, div_out, tick, busy}, {9'd0, model_out()});
`ifdef TICK_SCHED_CNT_EN
    check({name, "_rc"}, run_cycles, 16'(m_rc));
`endif
  endtask

  // Called right after a falling edge; returns right after the next one.
  task automatic cycle(input logic s, input logic t);
    start = s;
    stop  = t;
    @(posedge clk);
    model_step(s, t);
    #1;
    check_model("model");
    @(negedge clk);
  endtask

  // Called right after a falling edge; reset pulse ends before the next rise.
  task automatic do_reset(input string name);
    start = 1'b0;
    stop  = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check(name, {13'd0, div_out, tick, busy}, 16'd0);
    model_reset();
    #1 rst_n = 1'b1;
  endtask

  typedef struct {
    logic       s;
    logic       t;
    logic [2:0] div;
    logic [2:0] tck;
    logic       bsy;
  } vec_t;

  vec_t tbl [16];

  initial begin : main
    int tick_cnt [3];
    int hi_cnt [3];
    int n;
    int ch2_hi;

    // Start edge is row 1; rows show outputs just after each edge.
    tbl[0]  = '{1'b0, 1'b0, 3'b000, 3'b000, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 3'b000, 3'b000, 1'b1};  // -> arm
    tbl[2]  = '{1'b0, 1'b0, 3'b000, 3'b000, 1'b1};  // -> run
    tbl[3]  = '{1'b0, 1'b0, 3'b001, 3'b001, 1'b1};  // ch0 rises at E+2
    tbl[4]  = '{1'b0, 1'b0, 3'b010, 3'b010, 1'b1};  // ch1 rises at E+3
    tbl[5]  = '{1'b0, 1'b0, 3'b011, 3'b001, 1'b1};
    tbl[6]  = '{1'b1, 1'b0, 3'b100, 3'b100, 1'b1};  // ch2 rises at E+5; start ignored
    tbl[7]  = '{1'b0, 1'b0, 3'b101, 3'b001, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 3'b110, 3'b010, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, 3'b111, 3'b001, 1'b1};
    tbl[10] = '{1'b0, 1'b1, 3'b000, 3'b000, 1'b1};  // stop while 111 -> drain
    tbl[11] = '{1'b0, 1'b0, 3'b000, 3'b000, 1'b0};  // all parked -> idle
    tbl[12] = '{1'b1, 1'b1, 3'b000, 3'b000, 1'b0};  // start+stop in idle
    tbl[13] = '{1'b1, 1'b0, 3'b000, 3'b000, 1'b1};  // -> arm
    tbl[14] = '{1'b0, 1'b1, 3'b000, 3'b000, 1'b0};  // stop in arm -> idle
    tbl[15] = '{1'b0, 1'b0, 3'b000, 3'b000, 1'b0};

    rst_n = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    model_reset();
    #1;
    check("reset_state", {13'd0, div_out, tick, busy}, 16'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table.
    for (int k = 0; k < 16; k++) begin
      start = tbl[k].s;
      stop  = tbl[k].t;
      @(posedge clk);
      model_step(tbl[k].s, tbl[k].t);
      #1;
      check($sformatf("tbl_row%0d", k), {9'd0, div_out, tick, busy},
            {9'd0, tbl[k].div, tbl[k].tck, tbl[k].bsy});
      @(negedge clk);
    end

    // 64 run cycles: tick counts and duty.
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick_cnt[i] = 0;
      hi_cnt[i]   = 0;
    end
    for (int c = 0; c < 64; c++) begin
      cycle(1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
        tick_cnt[i] += int'(tick[i]);
        hi_cnt[i]   += int'(div_out[i]);
      end
    end
    check("ticks_ch0", 16'(tick_cnt[0]), 16'd32);
    check("ticks_ch1", 16'(tick_cnt[1]), 16'd16);
    check("ticks_ch2", 16'(tick_cnt[2]), 16'd8);
    check("duty_ch0", 16'(hi_cnt[0]), 16'd32);
    check("duty_ch1", 16'(hi_cnt[1]), 16'd32);
    check("duty_ch2", 16'(hi_cnt[2]), 16'd32);
    cycle(1'b0, 1'b1);
    n = 0;
    while (busy && n < 20) begin
      cycle(1'b0, 1'b0);
      n++;
    end
    check("drain1_idle", {15'd0, busy}, 16'd0);

    // Stop one edge after ch2 rises: ch2 must still complete four high cycles.
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    ch2_hi = 0;
    for (int c = 0; c < 4; c++) begin
      cycle(1'b0, 1'b0);
      ch2_hi += int'(div_out[2]);
    end
    cycle(1'b0, 1'b1);
    ch2_hi += int'(div_out[2]);
    n = 0;
    while (busy && n < 20) begin
      cycle(1'b0, 1'b0);
      ch2_hi += int'(div_out[2]);
      n++;
    end
    check("drain2_len", 16'(n), 16'd4);
    check("drain2_ch2_high", 16'(ch2_hi), 16'd4);
    check("drain2_div", {13'd0, div_out}, 16'd0);

    // Reset in the middle of run, then nothing should move without start.
    cycle(1'b1, 1'b0);
    for (int c = 0; c < 6; c++) cycle(1'b0, 1'b0);
    do_reset("rst_mid_run");
    for (int c = 0; c < 10; c++) cycle(1'b0, 1'b0);

`ifdef TICK_SCHED_CNT_EN
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    for (int c = 0; c < 99; c++) cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b1);
    check("rc_after_stop", run_cycles, 16'd100);
    n = 0;
    while (busy && n < 20) begin
      cycle(1'b0, 1'b0);
      n++;
    end
    check("rc_idle_hold", run_cycles, 16'd100);
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    check("rc_cleared", run_cycles, 16'd0);
`endif

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 199) == 0) do_reset("rst_random");
      cycle(($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/tick_scheduler.md
TICK_SCHEDULER -- requirements
Module: tick_scheduler

Interface
REQ-001 Parameter DIV0, default 2, period of div_out[0] in clk cycles (even, >=2).
REQ-002 Parameter DIV1, default 4, period of div_out[1] in clk cycles (even, >=2).
REQ-003 Parameter DIV2, default 8, period of div_out[2] in clk cycles (even, >=2).
REQ-004 Parameter CNT_W, default 8, width of each per-channel half-period counter; SHALL satisfy 2^CNT_W >= DIVi/2.
REQ-005 clk  input  1  single clock, all state on rising edge.
REQ-006 rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-007 start  input  1  one-cycle request to begin generation.
REQ-008 stop  input  1  one-cycle request to end generation cleanly.
REQ-009 div_out  output  3  divided square waves, bit i has period DIVi, 50% duty.
REQ-010 tick  output  3  one-cycle pulse per channel, high in the first cycle div_out[i] is high.
REQ-011 busy  output  1  high in any state other than IDLE.

Function
REQ-012 FSM states SHALL be IDLE, ARM, RUN, DRAIN; all outputs registered.
REQ-013 IDLE: start=1 and stop=0 -> ARM; otherwise stay IDLE.
REQ-014 ARM lasts exactly one cycle: clears all counters and div_out; stop=1 -> IDLE, else -> RUN.
REQ-015 RUN: counter i increments every clk edge; on reaching DIVi/2-1 it wraps to 0 and div_out[i] toggles in the same edge.
REQ-016 Latency: start sampled at edge E -> ARM after E, RUN after E+1, div_out[i] first rises at edge E+1+DIVi/2.
REQ-017 tick[i] SHALL be 1 exactly in cycles where div_out[i] just toggled 0->1; 0 otherwise.
REQ-018 RUN: stop=1 -> DRAIN; start in RUN or DRAIN ignored.
REQ-019 DRAIN: channel i keeps counting until div_out[i]=0 and counter i=0, then freezes there.
REQ-020 DRAIN: when all three channels frozen -> IDLE; no partial high pulse is ever truncated.
REQ-021 Simultaneous start and stop: in IDLE stop wins (stay IDLE); in RUN stop wins (-> DRAIN).
REQ-022 Counter wrap SHALL not overflow CNT_W; DIVi/2=1 means toggle every edge.

Reset
REQ-023 rst=0 SHALL immediately force state IDLE, counters 0, div_out=000, tick=000, busy=0, regardless of clk.
REQ-024 Reset asserted mid-RUN or mid-DRAIN SHALL abort with no further toggles; after release block waits in IDLE for start.
REQ-025 Release of rst SHALL take effect on the next rising clk edge with no spurious tick.

Configuration
REQ-026 Macro TICK_SCHED_CNT_EN defined: adds output run_cycles (16 bits), counts clk edges spent in RUN, saturates at 0xFFFF, cleared in ARM and by reset, held in IDLE/DRAIN.
REQ-027 Macro TICK_SCHED_CNT_EN undefined: run_cycles port and its counter absent; all other behaviour identical.

Verification
REQ-028 Reset: rst=0 mid-RUN at arbitrary time -> div_out=000, tick=000, busy=0 same time, before next clk edge.
REQ-029 Defaults, start pulse at edge 10 -> div_out[0] rises at edge 12, [1] at 13, [2] at 15; periods 2/4/8 cycles, ticks one cycle each.
REQ-030 Run 64 RUN cycles -> exactly 32/16/8 tick pulses on channels 0/1/2 and 50% duty measured on all.
REQ-031 stop while div_out=111 -> busy stays 1 until div_out[2] completes its high half, then IDLE with div_out=000, no truncated high pulse.
REQ-032 start and stop same cycle in IDLE -> busy stays 0; start during RUN -> no phase disturbance.
REQ-033 TICK_SCHED_CNT_EN defined, 100 RUN cycles then stop -> run_cycles=100 held in DRAIN/IDLE, cleared to 0 on next ARM.
